mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/cpu_defs_pkg.sv | 62 ++++++
 rtl/mc_cu_decode.sv | 133 +++++++++++++
 rtl/mc_control_unit.sv | 95 +++++++++
 tb/tb_mc_control_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM states, opcodes,
// ALU operations, PC source and write-register selects, plus the decoded control bundle.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_AL = 3'b010,
    ST_EXE_BR = 3'b011,
    ST_EXE_LS = 3'b100,
    ST_MEM    = 3'b101,
    ST_WB     = 3'b110,
    ST_HALT   = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] REG_RA = 2'b00;
  localparam logic [1:0] REG_RT = 2'b01;
  localparam logic [1:0] REG_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       ext_sel;
    logic       reg_wre;
    logic [1:0] reg_out;
    logic       alu_src_b;
    logic       alu_m2reg;
    logic       wr_reg_pc;
    logic       data_mem_en;
    logic       data_mem_rw;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational control decode: current state, opcode and flags to control bundle
// and next FSM state.
module mc_cu_decode
  import cpu_defs_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_e          state_q,
  input  logic [OP_W-1:0] operation,
  input  logic            zero,
  input  logic            imem_rdy,
  input  logic            dmem_rdy,
  output ctrl_t           ctrl,
  output state_e          state_d
);

  logic       is_imm;
  logic       is_alu;
  logic       is_lw;
  logic       is_sw;
  logic [2:0] alu_sel;

  always_comb begin
    is_imm  = 1'b0;
    is_alu  = 1'b1;
    alu_sel = ALU_ADD;
    is_lw   = (operation == OP_W'(OP_LW));
    is_sw   = (operation == OP_W'(OP_SW));
    case (operation)
      OP_W'(OP_ADD):  alu_sel = ALU_ADD;
      OP_W'(OP_SUB):  alu_sel = ALU_SUB;
      OP_W'(OP_OR):   alu_sel = ALU_OR;
      OP_W'(OP_AND):  alu_sel = ALU_AND;
      OP_W'(OP_ADDI): begin alu_sel = ALU_ADD; is_imm = 1'b1; end
      OP_W'(OP_ORI):  begin alu_sel = ALU_OR;  is_imm = 1'b1; end
      default:        is_alu = 1'b0;
    endcase
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    unique case (state_q)
      ST_IF: begin
        ctrl.ins_mem_rw = 1'b1;
        if (imem_rdy) begin
          ctrl.ir_wre = 1'b1;
          state_d     = ST_ID;
        end
      end
      ST_ID: begin
        case (operation)
          OP_W'(OP_J): begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PC_JUMP;
            state_d     = ST_IF;
          end
          OP_W'(OP_JAL): begin
            ctrl.pc_wre    = 1'b1;
            ctrl.pc_src    = PC_JUMP;
            ctrl.reg_wre   = 1'b1;
            ctrl.reg_out   = REG_RA;
            ctrl.wr_reg_pc = 1'b1;
            state_d        = ST_IF;
          end
          OP_W'(OP_JR): begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PC_REG;
            state_d     = ST_IF;
          end
          OP_W'(OP_BEQ):                 state_d = ST_EXE_BR;
          OP_W'(OP_LW), OP_W'(OP_SW):    state_d = ST_EXE_LS;
          OP_W'(OP_HALT):                state_d = ST_HALT;
          default: begin
            if (is_alu) begin
              state_d = ST_EXE_AL;
            end else begin
              // Undefined opcodes are skipped like a NOP and still retire.
              ctrl.pc_wre  = 1'b1;
              ctrl.pc_src  = PC_NEXT;
              ctrl.illegal = 1'b1;
              state_d      = ST_IF;
            end
          end
        endcase
      end
      ST_EXE_AL: begin
        ctrl.alu_op    = alu_sel;
        ctrl.alu_src_b = is_imm;
        ctrl.ext_sel   = (operation == OP_W'(OP_ADDI));
        ctrl.reg_out   = is_imm ? REG_RT : REG_RD;
        state_d        = ST_WB;
      end
      ST_EXE_BR: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_src_b = 1'b0;
        ctrl.pc_wre    = 1'b1;
        ctrl.pc_src    = zero ? PC_BRANCH : PC_NEXT;
        state_d        = ST_IF;
      end
      ST_EXE_LS: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
        state_d        = ST_MEM;
      end
      ST_MEM: begin
        ctrl.data_mem_en = 1'b1;
        ctrl.data_mem_rw = is_sw;
        if (dmem_rdy) begin
          if (is_sw) begin
            ctrl.pc_wre = 1'b1;
            state_d     = ST_IF;
          end else begin
            state_d     = ST_WB;
          end
        end
      end
      ST_WB: begin
        ctrl.reg_wre   = 1'b1;
        ctrl.pc_wre    = 1'b1;
        ctrl.pc_src    = PC_NEXT;
        ctrl.alu_m2reg = is_lw;
        ctrl.reg_out   = (is_lw || is_imm) ? REG_RT : REG_RD;
        state_d        = ST_IF;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: FSM state register, retired-instruction counter
// and reset gating of the enables produced by mc_cu_decode.
module mc_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int ALUOP_W       = 3,
  parameter int CNT_W         = 32,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    operation,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ExtSel,
  output logic               RegWre,
  output logic [1:0]         RegOut,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               WrRegPC,
  output logic               DataMemEn,
  output logic               DataMemRW,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctrl_t              ctrl;
  logic               imem_rdy;
  logic               dmem_rdy;

  always_comb begin
    imem_rdy = (MEM_HANDSHAKE != 0) ? imem_ready : 1'b1;
    dmem_rdy = (MEM_HANDSHAKE != 0) ? dmem_ready : 1'b1;
  end

  mc_cu_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .state_q   (state_q),
    .operation (operation),
    .zero      (zero),
    .imem_rdy  (imem_rdy),
    .dmem_rdy  (dmem_rdy),
    .ctrl      (ctrl),
    .state_d   (state_d)
  );

  // Enables are forced low while reset is held so nothing fires mid-reset.
  always_comb begin
    PCWre       = ctrl.pc_wre      & Reset;
    IRWre       = ctrl.ir_wre      & Reset;
    RegWre      = ctrl.reg_wre     & Reset;
    DataMemEn   = ctrl.data_mem_en & Reset;
    illegal     = ctrl.illegal     & Reset;
    InsMemRW    = ctrl.ins_mem_rw;
    ExtSel      = ctrl.ext_sel;
    RegOut      = ctrl.reg_out;
    ALUSrcB     = ctrl.alu_src_b;
    ALUM2Reg    = ctrl.alu_m2reg;
    WrRegPC     = ctrl.wr_reg_pc;
    DataMemRW   = ctrl.data_mem_rw;
    PCSrc       = ctrl.pc_src;
    ALUOp       = ALUOP_W'(ctrl.alu_op);
    halted      = ctrl.halted;
    state       = state_q;
    instr_count = cnt_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (PCWre) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; a second instance with a 2-bit counter
// and handshakes disabled covers counter wrap and ready bypass.
module tb_mc_control_unit;
  import cpu_defs_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset, zero, imem_ready, dmem_ready;
  logic [5:0] operation;

  logic       PCWre, IRWre, InsMemRW, ExtSel, RegWre, ALUSrcB, ALUM2Reg, WrRegPC;
  logic       DataMemEn, DataMemRW, illegal, halted;
  logic [1:0] RegOut, PCSrc;
  logic [2:0] ALUOp, state;
  logic [31:0] instr_count;

  logic       PCWre2, IRWre2, InsMemRW2, ExtSel2, RegWre2, ALUSrcB2, ALUM2Reg2, WrRegPC2;
  logic       DataMemEn2, DataMemRW2, illegal2, halted2;
  logic [1:0] RegOut2, PCSrc2;
  logic [2:0] ALUOp2, state2;
  logic [1:0] instr_count2;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  mc_control_unit dut (
    .CLK(CLK), .Reset(Reset), .operation(operation), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .RegWre(RegWre), .RegOut(RegOut), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
    .WrRegPC(WrRegPC), .DataMemEn(DataMemEn), .DataMemRW(DataMemRW),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state), .illegal(illegal),
    .halted(halted), .instr_count(instr_count)
  );

  mc_control_unit #(.CNT_W(2), .MEM_HANDSHAKE(0)) dut2 (
    .CLK(CLK), .Reset(Reset), .operation(operation), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWre(PCWre2), .IRWre(IRWre2), .InsMemRW(InsMemRW2), .ExtSel(ExtSel2),
    .RegWre(RegWre2), .RegOut(RegOut2), .ALUSrcB(ALUSrcB2), .ALUM2Reg(ALUM2Reg2),
    .WrRegPC(WrRegPC2), .DataMemEn(DataMemEn2), .DataMemRW(DataMemRW2),
    .PCSrc(PCSrc2), .ALUOp(ALUOp2), .state(state2), .illegal(illegal2),
    .halted(halted2), .instr_count(instr_count2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0; zero = 1'b0; operation = OP_ADD;
    step(); step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", instr_count); end
    checks++; if (IRWre !== 1'b0) begin failures++; $display("FAIL reset_irwre got=%0b want=0", IRWre); end
    checks++; if (PCWre !== 1'b0) begin failures++; $display("FAIL reset_pcwre got=%0b want=0", PCWre); end
    exp_cnt = 0;
  endtask

  task automatic test_add();
    operation = OP_ADD; imem_ready = 1'b1; Reset = 1'b1; #1;
    checks++; if (IRWre !== 1'b1) begin failures++; $display("FAIL add_if_irwre got=%0b want=1", IRWre); end
    checks++; if (InsMemRW !== 1'b1) begin failures++; $display("FAIL add_if_insmemrw got=%0b want=1", InsMemRW); end
    checks++; if (RegWre !== 1'b0) begin failures++; $display("FAIL add_if_regwre got=%0b want=0", RegWre); end
    step();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL add_id_state got=%0d want=1", state); end
    checks++; if (RegWre !== 1'b0) begin failures++; $display("FAIL add_id_regwre got=%0b want=0", RegWre); end
    step();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL add_exe_state got=%0d want=2", state); end
    checks++; if (ALUSrcB !== 1'b0) begin failures++; $display("FAIL add_exe_alusrcb got=%0b want=0", ALUSrcB); end
    checks++; if (RegOut !== 2'b10) begin failures++; $display("FAIL add_exe_regout got=%0d want=2", RegOut); end
    checks++; if (ALUOp !== 3'b000) begin failures++; $display("FAIL add_exe_aluop got=%0d want=0", ALUOp); end
    checks++; if (RegWre !== 1'b0) begin failures++; $display("FAIL add_exe_regwre got=%0b want=0", RegWre); end
    step();
    checks++; if (state !== 3'd6) begin failures++; $display("FAIL add_wb_state got=%0d want=6", state); end
    checks++; if (RegWre !== 1'b1) begin failures++; $display("FAIL add_wb_regwre got=%0b want=1", RegWre); end
    checks++; if (PCWre !== 1'b1) begin failures++; $display("FAIL add_wb_pcwre got=%0b want=1", PCWre); end
    checks++; if (ALUM2Reg !== 1'b0) begin failures++; $display("FAIL add_wb_alum2reg got=%0b want=0", ALUM2Reg); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL add_wb_count got=%0d want=0", instr_count); end
    step();
    exp_cnt = 1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL add_done_state got=%0d want=0", state); end
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL add_done_count got=%0d want=%0d", instr_count, exp_cnt); end
  endtask

  task automatic test_beq();
    operation = OP_BEQ; zero = 1'b1;
    step();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL beq_id_state got=%0d want=1", state); end
    step();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL beq_t_state got=%0d want=3", state); end
    checks++; if (PCSrc !== 2'b01) begin failures++; $display("FAIL beq_t_pcsrc got=%0d want=1", PCSrc); end
    checks++; if (PCWre !== 1'b1) begin failures++; $display("FAIL beq_t_pcwre got=%0b want=1", PCWre); end
    checks++; if (ALUOp !== 3'b001) begin failures++; $display("FAIL beq_t_aluop got=%0d want=1", ALUOp); end
    step(); exp_cnt++;
    zero = 1'b0;
    step(); step();
    checks++; if (PCSrc !== 2'b00) begin failures++; $display("FAIL beq_nt_pcsrc got=%0d want=0", PCSrc); end
    checks++; if (PCWre !== 1'b1) begin failures++; $display("FAIL beq_nt_pcwre got=%0b want=1", PCWre); end
    step(); exp_cnt++;
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL beq_count got=%0d want=%0d", instr_count, exp_cnt); end
  endtask

  task automatic test_lw();
    operation = OP_LW; dmem_ready = 1'b0;
    step(); step();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL lw_exe_state got=%0d want=4", state); end
    checks++; if (ALUSrcB !== 1'b1) begin failures++; $display("FAIL lw_exe_alusrcb got=%0b want=1", ALUSrcB); end
    checks++; if (ExtSel !== 1'b1) begin failures++; $display("FAIL lw_exe_extsel got=%0b want=1", ExtSel); end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1'b1;
      #1;
      checks++; if (state !== 3'd5) begin failures++; $display("FAIL lw_mem%0d_state got=%0d want=5", i, state); end
      checks++; if (DataMemEn !== 1'b1) begin failures++; $display("FAIL lw_mem%0d_en got=%0b want=1", i, DataMemEn); end
      checks++; if (DataMemRW !== 1'b0) begin failures++; $display("FAIL lw_mem%0d_rw got=%0b want=0", i, DataMemRW); end
      checks++; if (PCWre !== 1'b0) begin failures++; $display("FAIL lw_mem%0d_pcwre got=%0b want=0", i, PCWre); end
      step();
    end
    dmem_ready = 1'b0;
    checks++; if (state !== 3'd6) begin failures++; $display("FAIL lw_wb_state got=%0d want=6", state); end
    checks++; if (ALUM2Reg !== 1'b1) begin failures++; $display("FAIL lw_wb_alum2reg got=%0b want=1", ALUM2Reg); end
    checks++; if (RegWre !== 1'b1) begin failures++; $display("FAIL lw_wb_regwre got=%0b want=1", RegWre); end
    step(); exp_cnt++;
  endtask

  task automatic test_jal();
    operation = OP_JAL;
    step();
    checks++; if (PCSrc !== 2'b10) begin failures++; $display("FAIL jal_pcsrc got=%0d want=2", PCSrc); end
    checks++; if (RegOut !== 2'b00) begin failures++; $display("FAIL jal_regout got=%0d want=0", RegOut); end
    checks++; if (WrRegPC !== 1'b1) begin failures++; $display("FAIL jal_wrregpc got=%0b want=1", WrRegPC); end
    checks++; if (RegWre !== 1'b1) begin failures++; $display("FAIL jal_regwre got=%0b want=1", RegWre); end
    checks++; if (PCWre !== 1'b1) begin failures++; $display("FAIL jal_pcwre got=%0b want=1", PCWre); end
    step(); exp_cnt++;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL jal_next_state got=%0d want=0", state); end
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL jal_count got=%0d want=%0d", instr_count, exp_cnt); end
  endtask

  task automatic test_illegal_halt();
    operation = 6'b101010;
    step();
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%0b want=1", illegal); end
    checks++; if (PCWre !== 1'b1) begin failures++; $display("FAIL ill_pcwre got=%0b want=1", PCWre); end
    checks++; if (PCSrc !== 2'b00) begin failures++; $display("FAIL ill_pcsrc got=%0d want=0", PCSrc); end
    step(); exp_cnt++;
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_after got=%0b want=0", illegal); end
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL ill_count got=%0d want=%0d", instr_count, exp_cnt); end
    operation = OP_HALT;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt%0d_halted got=%0b want=1", i, halted); end
      checks++; if (state !== 3'd7) begin failures++; $display("FAIL halt%0d_state got=%0d want=7", i, state); end
      checks++; if (PCWre !== 1'b0 || IRWre !== 1'b0 || RegWre !== 1'b0 || DataMemEn !== 1'b0) begin
        failures++; $display("FAIL halt%0d_enables got=%0b%0b%0b%0b want=0000", i, PCWre, IRWre, RegWre, DataMemEn);
      end
      step();
    end
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL halt_count got=%0d want=%0d", instr_count, exp_cnt); end
    Reset = 1'b0;
    step(); exp_cnt = 0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL halt_rst_state got=%0d want=0", state); end
    checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL halt_rst_count got=%0d want=0", instr_count); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_rst_halted got=%0b want=0", halted); end
  endtask

  task automatic test_reset_mid_mem();
    operation = OP_SW; dmem_ready = 1'b0; Reset = 1'b1; #1;
    step(); step(); step();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL rmm_state got=%0d want=5", state); end
    checks++; if (DataMemEn !== 1'b1) begin failures++; $display("FAIL rmm_en got=%0b want=1", DataMemEn); end
    checks++; if (DataMemRW !== 1'b1) begin failures++; $display("FAIL rmm_rw got=%0b want=1", DataMemRW); end
    Reset = 1'b0; #1;
    checks++; if (DataMemEn !== 1'b0) begin failures++; $display("FAIL rmm_en_inrst got=%0b want=0", DataMemEn); end
    step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rmm_after_state got=%0d want=0", state); end
    checks++; if (DataMemEn !== 1'b0) begin failures++; $display("FAIL rmm_after_en got=%0b want=0", DataMemEn); end
    exp_cnt = 0;
  endtask

  task automatic test_back_to_back();
    Reset = 1'b1; operation = OP_ORI; imem_ready = 1'b1; #1;
    step(); step();
    checks++; if (RegOut !== 2'b01) begin failures++; $display("FAIL ori_regout got=%0d want=1", RegOut); end
    checks++; if (ALUSrcB !== 1'b1) begin failures++; $display("FAIL ori_alusrcb got=%0b want=1", ALUSrcB); end
    checks++; if (ExtSel !== 1'b0) begin failures++; $display("FAIL ori_extsel got=%0b want=0", ExtSel); end
    checks++; if (ALUOp !== 3'b010) begin failures++; $display("FAIL ori_aluop got=%0d want=2", ALUOp); end
    step();
    checks++; if (RegOut !== 2'b01) begin failures++; $display("FAIL ori_wb_regout got=%0d want=1", RegOut); end
    step(); exp_cnt++;
    operation = OP_SW; dmem_ready = 1'b1;
    step(); step(); step();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL sw_mem_state got=%0d want=5", state); end
    checks++; if (PCWre !== 1'b1) begin failures++; $display("FAIL sw_mem_pcwre got=%0b want=1", PCWre); end
    checks++; if (DataMemRW !== 1'b1) begin failures++; $display("FAIL sw_mem_rw got=%0b want=1", DataMemRW); end
    step(); exp_cnt++;
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", instr_count, exp_cnt); end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    step(); step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL if_stall_state got=%0d want=0", state); end
    checks++; if (IRWre !== 1'b0) begin failures++; $display("FAIL if_stall_irwre got=%0b want=0", IRWre); end
  endtask

  task automatic test_wrap();
    Reset = 1'b0; imem_ready = 1'b1; step();
    Reset = 1'b1; operation = OP_J; exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (PCSrc !== 2'b10) begin failures++; $display("FAIL j%0d_pcsrc got=%0d want=2", k, PCSrc); end
      step(); exp_cnt++;
    end
    checks++; if (instr_count !== 32'(exp_cnt)) begin failures++; $display("FAIL wrap_count32 got=%0d want=%0d", instr_count, exp_cnt); end
    checks++; if (instr_count2 !== 2'd1) begin failures++; $display("FAIL wrap_count2 got=%0d want=1", instr_count2); end
    imem_ready = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL hs_on_state got=%0d want=0", state); end
    checks++; if (state2 !== 3'd1) begin failures++; $display("FAIL hs_off_state got=%0d want=1", state2); end
  endtask

  initial begin
    Reset = 1'b0; operation = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_beq();
    test_lw();
    test_jal();
    test_illegal_halt();
    test_reset_mid_mem();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
